// File: rtl/iir_pkg.sv
// Shared constants for the IIR filter output path: statistics counter width
// and helpers that give the signed saturation limits for an output width.
package iir_pkg;

   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic signed [63:0] sat_hi(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_lo(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/iir_sync_fifo.sv
// Synchronous first-word fall-through FIFO; rd_data shows the head entry
// whenever the FIFO is non-empty and reads zero when empty.
module iir_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      level <= level + LW'(1);
         else if (!do_push && do_pop) level <= level - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/iir_output_stage.sv
// IIR output stage: aligns the input valid with the filter latency, saturates
// y to OUT_WIDTH, buffers results in a FIFO and keeps saturation/drop stats.
module iir_output_stage
   import iir_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_WIDTH  = 16,
   parameter int LATENCY    = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic signed [DATA_WIDTH-1:0]  y_in,
   output logic signed [OUT_WIDTH-1:0]   out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   input  logic                          clr_stats,
   output logic                          sat_sticky,
   output logic [CNT_W-1:0]              sat_count,
   output logic [CNT_W-1:0]              drop_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam logic signed [63:0] Y_MAX = sat_hi(OUT_WIDTH);
   localparam logic signed [63:0] Y_MIN = sat_lo(OUT_WIDTH);

   function automatic logic is_sat(input logic signed [DATA_WIDTH-1:0] y);
      logic signed [63:0] y_ext;
      y_ext = 64'(y);
      return (y_ext > Y_MAX) || (y_ext < Y_MIN);
   endfunction

   function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [DATA_WIDTH-1:0] y);
      logic signed [63:0] y_ext;
      y_ext = 64'(y);
      if (y_ext > Y_MAX)      return OUT_WIDTH'(Y_MAX);
      else if (y_ext < Y_MIN) return OUT_WIDTH'(Y_MIN);
      else                    return y[OUT_WIDTH-1:0];
   endfunction

   logic [LATENCY-1:0]            vld_dly;
   logic                          vld_p0;
   logic                          sat_hit_p0;
   logic                          vld_p1;
   logic signed [OUT_WIDTH-1:0]   sat_p1;
   logic                          fifo_empty;
   logic                          fifo_full;
   logic [OUT_WIDTH-1:0]          fifo_rd;
   logic                          pop;
   logic                          push;
   logic                          drop;

   // Stage p0: valid tap lines up with the cycle y_in carries that sample
   assign vld_p0     = vld_dly[LATENCY-1];
   assign sat_hit_p0 = vld_p0 && is_sat(y_in);

   // Stage p1: saturation register feeding the FIFO write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_dly <= '0;
         vld_p1  <= 1'b0;
         sat_p1  <= '0;
      end else begin
         vld_dly <= (vld_dly << 1) | LATENCY'(in_valid);
         vld_p1  <= vld_p0;
         if (vld_p0) sat_p1 <= saturate(y_in);
      end
   end

   assign out_valid = !fifo_empty;
   assign out_data  = fifo_rd;
   assign pop       = out_valid && out_ready;
   assign push      = vld_p1 && (!fifo_full || pop);
   assign drop      = vld_p1 && fifo_full && !pop;

   iir_sync_fifo #(
      .WIDTH (OUT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .wr_data (sat_p1),
      .rd_data (fifo_rd),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .level   (fifo_level)
   );

   // Clear takes priority over any increment in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_sticky <= 1'b0;
         sat_count  <= '0;
         drop_count <= '0;
      end else if (clr_stats) begin
         sat_sticky <= 1'b0;
         sat_count  <= '0;
         drop_count <= '0;
      end else begin
         if (sat_hit_p0) begin
            sat_sticky <= 1'b1;
            if (sat_count != CNT_MAX) sat_count <= sat_count + CNT_W'(1);
         end
         if (drop && (drop_count != CNT_MAX)) drop_count <= drop_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_iir_output_stage.sv
// Bench for iir_output_stage: directed scenarios plus random traffic, all
// compared every cycle against a queue-based reference model.
module tb_iir_output_stage;

   localparam int DW    = 32;
   localparam int OW    = 16;
   localparam int LAT   = 4;
   localparam int DEPTH = 8;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    in_valid = 1'b0;
   logic signed [DW-1:0]    y_in = '0;
   logic [OW-1:0]           out_data;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic                    clr_stats = 1'b0;
   logic                    sat_sticky;
   logic [15:0]             sat_count;
   logic [15:0]             drop_count;
   logic [$clog2(DEPTH):0]  fifo_level;

   always #5 clk = ~clk;

   iir_output_stage #(
      .DATA_WIDTH (DW),
      .OUT_WIDTH  (OW),
      .LATENCY    (LAT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .y_in       (y_in),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .clr_stats  (clr_stats),
      .sat_sticky (sat_sticky),
      .sat_count  (sat_count),
      .drop_count (drop_count),
      .fifo_level (fifo_level)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   logic [OW-1:0] mq[$];
   bit            vq[$];
   bit            pend_v;
   logic [OW-1:0] pend_d;
   int            m_sat;
   int            m_drop;
   bit            m_sticky;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit is_sat(input longint v);
      return (v > 32767) || (v < -32768);
   endfunction

   function automatic logic [OW-1:0] clamp(input longint v);
      if (v > 32767)  return 16'h7FFF;
      if (v < -32768) return 16'h8000;
      return v[15:0];
   endfunction

   function automatic int rnd_y();
      if ($urandom_range(0, 3) == 0) return int'($urandom());
      return int'($urandom_range(0, 80000)) - 40000;
   endfunction

   task automatic model_reset();
      mq.delete();
      vq.delete();
      for (int i = 0; i < LAT; i++) vq.push_back(1'b0);
      pend_v   = 1'b0;
      pend_d   = '0;
      m_sat    = 0;
      m_drop   = 0;
      m_sticky = 1'b0;
   endtask

   // One clock cycle: compare current outputs, drive inputs, advance the model.
   task automatic step(input bit iv, input int y, input bit rdy, input bit clr);
      bit     tap;
      bit     pop;
      bit     full;
      longint yv;
      chk("out_valid", out_valid, mq.size() != 0);
      chk("fifo_level", fifo_level, mq.size());
      if (mq.size() != 0) chk("out_data", out_data, mq[0]);
      chk("sat_count", sat_count, m_sat);
      chk("drop_count", drop_count, m_drop);
      chk("sat_sticky", sat_sticky, m_sticky);
      in_valid  = iv;
      y_in      = y;
      out_ready = rdy;
      clr_stats = clr;
      yv   = y;
      tap  = vq.pop_front();
      vq.push_back(iv);
      full = (mq.size() == DEPTH);
      pop  = (mq.size() != 0) && rdy;
      if (pop) void'(mq.pop_front());
      if (pend_v) begin
         if (!full || pop) mq.push_back(pend_d);
         else if (m_drop < 65535) m_drop++;
      end
      if (tap && is_sat(yv)) begin
         m_sticky = 1'b1;
         if (m_sat < 65535) m_sat++;
      end
      if (clr) begin
         m_sat    = 0;
         m_drop   = 0;
         m_sticky = 1'b0;
      end
      pend_v = tap;
      if (tap) pend_d = clamp(yv);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, rnd_y(), 1'b1, 1'b0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_fifo_level", fifo_level, 0);
      chk("rst_sat_count", sat_count, 0);
      chk("rst_drop_count", drop_count, 0);
      chk("rst_sat_sticky", sat_sticky, 0);
      rst_n = 1'b1;
      drain(6);

      // single sample: pulse at c0, y at c4, visible at c6
      step(1'b1, rnd_y(), 1'b0, 1'b0);
      for (int c = 1; c < 4; c++) step(1'b0, rnd_y(), 1'b0, 1'b0);
      step(1'b0, 1000, 1'b0, 1'b0);
      step(1'b0, rnd_y(), 1'b0, 1'b0);
      chk("lat_out_valid", out_valid, 1);
      chk("lat_out_data", out_data, 1000);
      drain(6);

      // positive and negative saturation
      step(1'b0, rnd_y(), 1'b0, 1'b1);
      step(1'b1, rnd_y(), 1'b0, 1'b0);
      step(1'b1, rnd_y(), 1'b0, 1'b0);
      step(1'b0, rnd_y(), 1'b0, 1'b0);
      step(1'b0, rnd_y(), 1'b0, 1'b0);
      step(1'b0, 40000, 1'b0, 1'b0);
      step(1'b0, -40000, 1'b0, 1'b0);
      step(1'b0, rnd_y(), 1'b0, 1'b0);
      step(1'b0, rnd_y(), 1'b0, 1'b0);
      chk("sat_pos_data", out_data, 16'h7FFF);
      chk("sat_level", fifo_level, 2);
      chk("sat_cnt2", sat_count, 2);
      chk("sat_sticky1", sat_sticky, 1);
      step(1'b0, rnd_y(), 1'b1, 1'b0);
      chk("sat_neg_data", out_data, 16'h8000);
      drain(6);

      // clear in the same cycle as a saturating sample
      step(1'b1, rnd_y(), 1'b1, 1'b0);
      for (int c = 1; c < 4; c++) step(1'b0, rnd_y(), 1'b1, 1'b0);
      step(1'b0, 50000, 1'b1, 1'b1);
      chk("clr_sat_count", sat_count, 0);
      chk("clr_sat_sticky", sat_sticky, 0);
      drain(8);

      // overflow: 10 samples into an 8-deep FIFO with no consumer
      step(1'b0, rnd_y(), 1'b0, 1'b1);
      for (int c = 0; c < 16; c++) step(c < 10, 100 + c - 4, 1'b0, 1'b0);
      chk("ovf_level", fifo_level, 8);
      chk("ovf_drop", drop_count, 2);
      chk("ovf_head", out_data, 100);

      // push and pop in the same cycle while full
      step(1'b1, rnd_y(), 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) step(1'b0, rnd_y(), 1'b0, 1'b0);
      step(1'b0, 555, 1'b0, 1'b0);
      step(1'b0, rnd_y(), 1'b1, 1'b0);
      chk("full_pp_level", fifo_level, 8);
      chk("full_pp_drop", drop_count, 2);
      for (int i = 0; i < 8; i++) begin
         chk("full_pp_order", out_data, (i < 7) ? 101 + i : 555);
         step(1'b0, rnd_y(), 1'b1, 1'b0);
      end
      chk("full_pp_empty", out_valid, 0);
      drain(4);

      // reset with 5 buffered samples and 2 in the delay line
      for (int c = 0; c < 5; c++) step(1'b1, rnd_y(), 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) step(1'b0, rnd_y(), 1'b0, 1'b0);
      step(1'b1, rnd_y(), 1'b0, 1'b0);
      step(1'b1, rnd_y(), 1'b0, 1'b0);
      chk("pre_rst_level", fifo_level, 5);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_level", fifo_level, 0);
      chk("mid_rst_out_data", out_data, 0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      clr_stats = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      drain(10);

      // random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 1) == 1, rnd_y(), $urandom_range(0, 9) < 6,
              $urandom_range(0, 49) == 0);
      drain(12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
